// File: rtl/jtdd_dip_decode_if.sv
// Status/DIP inputs toward the decoder and decoded DIP banks plus turbo back to the main CPU.
interface jtdd_dip_decode_if;
  logic [31:0] status;
  logic        dip_pause;
  logic        dip_test;
  logic        dip_flip;
  logic        turbo;
  logic [7:0]  dipsw_a;
  logic [7:0]  dipsw_b;

  modport slave (
    input  status, dip_pause, dip_test, dip_flip,
    output turbo, dipsw_a, dipsw_b
  );

  modport master (
    output status, dip_pause, dip_test, dip_flip,
    input  turbo, dipsw_a, dipsw_b
  );
endinterface

// File: rtl/jtdd_dip_decode.sv
// Double Dragon II DIP decode: maps the OSD status word to active-low DIP banks and turbo,
// committing a new snapshot only after it has held steady for STABLE_CYCLES clocks.
module jtdd_dip_decode #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  jtdd_dip_decode_if.slave  bus
);
  localparam int unsigned SNAP_W = 17;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [SNAP_W-1:0] SNAP_RST  = {1'b0, 16'hFFFF};

  logic [7:0]        na_c;
  logic [7:0]        nb_c;
  logic              nt_c;
  logic [SNAP_W-1:0] snap_c;

  logic [SNAP_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [SNAP_W-1:0] out_q,  out_d;

  // Low status bits and the test switch have no effect on any output.
  logic unused_c;
  assign unused_c = ^{bus.status[15:0], bus.dip_test};

  // Status word to switch mapping; status 0 is the factory default (all switches high).
  always_comb begin
    na_c[2:0] = ~bus.status[18:16];
    na_c[5:3] = ~bus.status[21:19];
    na_c[6]   = ~bus.status[22];
    na_c[7]   = ~bus.dip_flip;
    nb_c[1:0] = ~bus.status[24:23];
    nb_c[2]   = ~bus.status[25];
    nb_c[3]   = ~bus.status[26];
    nb_c[5:4] = ~bus.status[28:27];
    nb_c[7:6] = ~bus.status[30:29];
    nt_c      = bus.status[31] & bus.dip_pause;
    snap_c    = {nt_c, nb_c, na_c};
  end

  // Stability filter: the whole 17-bit vector is committed at once, never per bank.
  always_comb begin
    last_d = snap_c;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (snap_c != last_q) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end else begin
      out_d = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SNAP_RST;
      cnt_q  <= '0;
      out_q  <= SNAP_RST;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign bus.dipsw_a = out_q[7:0];
  assign bus.dipsw_b = out_q[15:8];
  assign bus.turbo   = out_q[16];
endmodule

// File: tb/tb_jtdd_dip_decode.sv
// Directed bench for jtdd_dip_decode with STABLE_CYCLES = 4.
module tb_jtdd_dip_decode;
  localparam int unsigned N = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  jtdd_dip_decode_if bus ();

  jtdd_dip_decode #(.STABLE_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; inputs are driven and outputs sampled on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                       input logic et);
    n_checks++;
    assert (bus.dipsw_a === ea && bus.dipsw_b === eb && bus.turbo === et)
    else begin
      n_fails++;
      $error("FAIL %s: observed a=%h b=%h t=%b expected a=%h b=%h t=%b",
             tag, bus.dipsw_a, bus.dipsw_b, bus.turbo, ea, eb, et);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst           = 1'b1;
    bus.status    = 32'h0;
    bus.dip_pause = 1'b1;
    bus.dip_test  = 1'b0;
    bus.dip_flip  = 1'b0;
    @(negedge clk);
    tick(2);
    check("reset", 8'hFF, 8'hFF, 1'b0);
    rst = 1'b0;

    // Factory default stays at all-high
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("default", 8'hFF, 8'hFF, 1'b0);
    end

    // Coin A change: visible on the (N+1)th edge, not before
    bus.status = 32'h0007_0000;
    for (int i = 1; i <= N; i++) begin
      tick(1);
      check("coin_a_early", 8'hFF, 8'hFF, 1'b0);
    end
    tick(1);
    check("coin_a_commit", 8'hF8, 8'hFF, 1'b0);
    tick(3);
    check("coin_a_hold", 8'hF8, 8'hFF, 1'b0);

    // Bank B all on plus turbo, atomically
    bus.status = 32'hFF80_0000;
    tick(N);
    check("bank_b_early", 8'hF8, 8'hFF, 1'b0);
    tick(1);
    check("bank_b_commit", 8'hFF, 8'h00, 1'b1);

    // Pause forces turbo off after the filter delay
    bus.dip_pause = 1'b0;
    tick(N);
    check("pause_early", 8'hFF, 8'h00, 1'b1);
    tick(1);
    check("pause_commit", 8'hFF, 8'h00, 1'b0);

    bus.status    = 32'h0;
    bus.dip_pause = 1'b1;
    tick(N + 1);
    check("back_default", 8'hFF, 8'hFF, 1'b0);

    // Flip pulse of N-1 cycles is rejected
    bus.dip_flip = 1'b1;
    tick(N - 1);
    bus.dip_flip = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      check("flip_glitch", 8'hFF, 8'hFF, 1'b0);
      tick(1);
    end

    // Flip held steady is accepted
    bus.dip_flip = 1'b1;
    tick(N);
    check("flip_early", 8'hFF, 8'hFF, 1'b0);
    tick(1);
    check("flip_commit", 8'h7F, 8'hFF, 1'b0);
    bus.dip_flip = 1'b0;
    tick(N + 1);
    check("flip_release", 8'hFF, 8'hFF, 1'b0);

    // Ignored inputs never disturb the outputs
    for (int i = 0; i < 100; i++) begin
      bus.dip_test       = 1'($urandom_range(1, 0));
      bus.status[15:0]   = 16'($urandom);
      tick(1);
      check("ignored_bits", 8'hFF, 8'hFF, 1'b0);
    end
    bus.dip_test   = 1'b0;
    bus.status     = 32'h0;

    // Reset mid-window discards the pending change
    bus.status = 32'h0007_0000;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_reset", 8'hFF, 8'hFF, 1'b0);
    for (int i = 1; i <= N; i++) begin
      tick(1);
      check("post_reset_early", 8'hFF, 8'hFF, 1'b0);
    end
    tick(1);
    check("post_reset_commit", 8'hF8, 8'hFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
